// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and default sizing for the SPI transfer controller and its FIFOs.
package spi_xfer_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int TMR_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } xfer_state_e;

endpackage

// File: rtl/spi_xfer_ctrl_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and a count-based full/empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is lost.
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Drains TX words one at a time into an SPI master and collects each reply
// into the RX FIFO, with a per-word timeout and sticky error flags.
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  tx_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rx_empty,
  input  logic                  enable,
  input  logic [1:0]            cfg_slave_sel,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic [1:0]            spi_slave_sel,
  output logic                  spi_cpol,
  output logic                  spi_cpha,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  input  logic                  spi_done,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_ovf,
  input  logic                  err_clr
);

  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  xfer_state_e           state_q;
  logic [TMR_W-1:0]      tmr_q;
  logic                  start_q, busy_q, cpol_q, cpha_q;
  logic [1:0]            sel_q;
  logic [DATA_WIDTH-1:0] txd_q;
  logic                  err_to_q, err_ovf_q;

  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_empty, rx_full;
  logic                  tx_pop, rx_push, to_hit;

  // A launch needs a free RX slot so the reply always has somewhere to land.
  assign tx_pop  = (state_q == ST_IDLE) && enable && !tx_empty && !rx_full;
  assign rx_push = (state_q == ST_WAIT_DONE) && spi_done;
  assign to_hit  = (state_q == ST_WAIT_DONE) && !spi_done && (tmr_q >= TO_LAST);

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (wr_en),
    .push_data_i(wr_data),
    .pop_i      (tx_pop),
    .pop_data_o (tx_head),
    .full_o     (tx_full),
    .empty_o    (tx_empty)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (rx_push),
    .push_data_i(spi_rx_data),
    .pop_i      (rd_en),
    .pop_data_o (rd_data),
    .full_o     (rx_full),
    .empty_o    (rx_empty)
  );

  // Timer reads 0 during LAUNCH, so TIMEOUT_CYCLES counts from the spi_start cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      txd_q   <= '0;
      sel_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_pop) begin
            state_q <= ST_LAUNCH;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            tmr_q   <= '0;
            txd_q   <= tx_head;
            sel_q   <= cfg_slave_sel;
            cpol_q  <= cfg_cpol;
            cpha_q  <= cfg_cpha;
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_WAIT_DONE;
          start_q <= 1'b0;
          tmr_q   <= tmr_q + TMR_W'(1);
        end
        ST_WAIT_DONE: begin
          if (spi_done || to_hit) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A set event in the same cycle as err_clr keeps the flag raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_to_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (to_hit)                err_to_q  <= 1'b1;
      else if (err_clr)          err_to_q  <= 1'b0;
      if (wr_en && tx_full)      err_ovf_q <= 1'b1;
      else if (err_clr)          err_ovf_q <= 1'b0;
    end
  end

  assign spi_start     = start_q;
  assign spi_tx_data   = txd_q;
  assign spi_slave_sel = sel_q;
  assign spi_cpol      = cpol_q;
  assign spi_cpha      = cpha_q;
  assign busy          = busy_q;
  assign err_timeout   = err_to_q;
  assign err_ovf       = err_ovf_q;

endmodule
